// File: rtl/mcycle_pkg.sv
// mcycle_pkg: shared definitions for the iterative multiply/divide unit.
//   - mc_op_e    : MCycleOp encodings (signed/unsigned MUL/DIV)
//   - mc_state_e : control FSM state encoding
//   - helpers    : op decode functions used by the control path
package mcycle_pkg;

    typedef enum logic [1:0] {
        MC_SMUL = 2'b00,
        MC_UMUL = 2'b01,
        MC_SDIV = 2'b10,
        MC_UDIV = 2'b11
    } mc_op_e;

    typedef enum logic [1:0] {
        MC_IDLE    = 2'b00,
        MC_COMPUTE = 2'b01,
        MC_DONE    = 2'b10
    } mc_state_e;

    function automatic logic mc_is_div(input mc_op_e op);
        return (op == MC_SDIV) || (op == MC_UDIV);
    endfunction

    function automatic logic mc_is_signed(input mc_op_e op);
        return (op == MC_SMUL) || (op == MC_SDIV);
    endfunction

endpackage

// File: rtl/mcycle_datapath.sv
// mcycle_datapath: shift registers and one iteration step per cycle.
//   MUL: shift-add into a 2*WIDTH accumulator (multiplier in the low half).
//   DIV: restoring division; quotient shifts into the low half of the
//        accumulator, remainder kept alongside.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   load            : capture op_a (multiplier/dividend) and op_b
//                     (multiplicand/divisor) magnitudes
//   step            : perform one iteration
//   is_div          : selects divide (1) or multiply (0) iteration
//   op_a, op_b      : operand magnitudes
//   lo_next, hi_next: next-state low/high result fields (product halves, or
//                     quotient/remainder), used on the final iteration edge
import mcycle_pkg::*;

module mcycle_datapath #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] lo_next,
    output logic [WIDTH-1:0] hi_next
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   b_q, b_d;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     partial;   // WIDTH+1-bit partial remainder for the trial
    logic               fits;
    logic [WIDTH-1:0]   sub;

    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        partial = {rem_q, acc_q[WIDTH-1]};
        fits    = partial >= {1'b0, b_q};
        // When the trial fits, the difference is below the divisor, so WIDTH bits suffice.
        sub     = partial[WIDTH-1:0] - b_q;

        acc_d = acc_q;
        rem_d = rem_q;
        b_d   = b_q;
        if (load) begin
            acc_d = {{WIDTH{1'b0}}, op_a};
            rem_d = '0;
            b_d   = op_b;
        end else if (step) begin
            if (is_div) begin
                rem_d = fits ? sub : partial[WIDTH-1:0];
                acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], fits};
            end else begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
        end

        lo_next = acc_d[WIDTH-1:0];
        hi_next = is_div ? rem_d : acc_d[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            rem_q <= '0;
            b_q   <= '0;
        end else begin
            acc_q <= acc_d;
            rem_q <= rem_d;
            b_q   <= b_d;
        end
    end

endmodule

// File: rtl/mcycle_unit.sv
// mcycle_unit: iterative multi-cycle multiply/divide unit (execute stage).
// Latency Start->Done is WIDTH+1 cycles; Busy stalls the pipeline meanwhile.
// Optional feature macro: MCYCLE_FLAGS_EN (registered {N,Z} on MulFlags;
// when undefined MulFlags is tied to zero).
// Ports:
//   CLK, RESET         : clock, synchronous active-high reset
//   Start              : request, sampled in IDLE or DONE
//   MCycleOp           : 00 SMUL, 01 UMUL, 10 SDIV, 11 UDIV
//   Operand1, Operand2 : multiplicand/dividend, multiplier/divisor
//   Result1, Result2   : MUL low/high product, DIV quotient/remainder
//   Busy               : combinational stall request
//   Done               : one-cycle pulse, results valid
//   MulFlags           : {N,Z} of the result
import mcycle_pkg::*;

module mcycle_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done,
    output logic [1:0]       MulFlags
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mc_state_e        state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             load, finish;

    mc_op_e           op;
    logic             div_zero, signed_eff;
    logic [WIDTH-1:0] mag1, mag2;

    logic             is_div_q, neg_res_q, neg_rem_q;
    logic [WIDTH-1:0] lo_next, hi_next;

    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s;
    logic [WIDTH-1:0]   result1_q, result1_d, result2_q, result2_d;

    // Control FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            MC_IDLE: begin
                if (Start) begin
                    state_d = MC_COMPUTE;
                    cnt_d   = '0;
                    load    = 1'b1;
                end
            end
            MC_COMPUTE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = MC_DONE;
                    cnt_d   = '0;
                    finish  = 1'b1;
                end
            end
            MC_DONE: begin
                if (Start) begin
                    state_d = MC_COMPUTE;
                    cnt_d   = '0;
                    load    = 1'b1;
                end else begin
                    state_d = MC_IDLE;
                end
            end
            default: state_d = MC_IDLE;
        endcase
    end

    assign Busy = (Start && (state_q == MC_IDLE || state_q == MC_DONE)) ||
                  (state_q == MC_COMPUTE);
    assign Done = (state_q == MC_DONE);

    // Operand conditioning. A zero divisor runs the unsigned path regardless of
    // op, which yields an all-ones quotient and the raw dividend as remainder.
    always_comb begin
        op         = mc_op_e'(MCycleOp);
        div_zero   = mc_is_div(op) && (Operand2 == '0);
        signed_eff = mc_is_signed(op) && !div_zero;
        mag1       = (signed_eff && Operand1[WIDTH-1]) ? -Operand1 : Operand1;
        mag2       = (signed_eff && Operand2[WIDTH-1]) ? -Operand2 : Operand2;
    end

    mcycle_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk     (CLK),
        .reset   (RESET),
        .load    (load),
        .step    (state_q == MC_COMPUTE),
        .is_div  (is_div_q),
        .op_a    (mag1),
        .op_b    (mag2),
        .lo_next (lo_next),
        .hi_next (hi_next)
    );

    // Sign correction on the final iteration's values, so results are
    // already registered when DONE is entered.
    always_comb begin
        prod   = {hi_next, lo_next};
        prod_s = neg_res_q ? -prod : prod;
        quo_s  = neg_res_q ? -lo_next : lo_next;
        rem_s  = neg_rem_q ? -hi_next : hi_next;

        result1_d = result1_q;
        result2_d = result2_q;
        if (finish) begin
            if (is_div_q) begin
                result1_d = quo_s;
                result2_d = rem_s;
            end else begin
                result1_d = prod_s[WIDTH-1:0];
                result2_d = prod_s[2*WIDTH-1:WIDTH];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= MC_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result1_q <= '0;
            result2_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            result1_q <= result1_d;
            result2_q <= result2_d;
            if (load) begin
                is_div_q  <= mc_is_div(op);
                neg_res_q <= signed_eff && (Operand1[WIDTH-1] ^ Operand2[WIDTH-1]);
                neg_rem_q <= signed_eff && Operand1[WIDTH-1];
            end
        end
    end

    assign Result1 = result1_q;
    assign Result2 = result2_q;

`ifdef MCYCLE_FLAGS_EN
    logic [1:0] flags_q, flags_d;

    always_comb begin
        flags_d = flags_q;
        if (finish) begin
            flags_d[1] = result1_d[WIDTH-1];
            flags_d[0] = is_div_q ? (result1_d == '0) : ({result2_d, result1_d} == '0);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            flags_q <= 2'b00;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign MulFlags = flags_q;
`else
    assign MulFlags = 2'b00;
`endif

endmodule
